// File: rtl/interrupt_control.sv
// Interrupt controller core of an 8259A-compatible PIC: IRR/ISR upkeep, rotating
// priority, fully nested INT generation and the two-pulse INTA vector sequence.
module interrupt_control #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic [7:0] IR,
   input  logic       INTA,
   input  logic       initStrobe,
   input  logic       ltim,
   input  logic [4:0] vectorBase,
   input  logic       aeoi,
   input  logic [7:0] imr,
   input  logic [7:0] ocw2,
   input  logic       ocw2Strobe,
   output logic       INT,
   output logic [7:0] dataOut,
   output logic       dataEn,
   output logic [7:0] irr,
   output logic [7:0] isr
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACK1  = 2'd1;
   localparam logic [1:0] S_WAIT2 = 2'd2;
   localparam logic [1:0] S_ACK2  = 2'd3;

   logic [7:0]             ir_sync_q [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] inta_sync_q;
   logic [7:0]             ir_s;
   logic                   inta_s;

   logic [1:0] state_q, state_d;
   logic [7:0] irr_q, irr_d, isr_q, isr_d, ack_mask;
   logic [7:0] ir_prev_q, data_out_q, data_out_d;
   logic [2:0] lo_pri_q, lo_pri_d, ack_lvl_q, ack_lvl_d;
   logic       inta_prev_q, spurious_q, spurious_d, rot_aeoi_q, rot_aeoi_d;
   logic       irq_q, irq_d, data_en_q, data_en_d;
   logic       inta_fall, inta_rise, int_cond;
   logic       cand_vld, isr_vld, eoi_vld;
   logic [2:0] cand_lvl, isr_lvl, eoi_lvl;
   logic       ocw2_unused;

   // OCW2[4:3] only select the register type upstream.
   assign ocw2_unused = ^ocw2[4:3];

   // Highest-priority set bit of vec when low is the lowest-priority level.
   function automatic logic [3:0] top_level(input logic [7:0] vec, input logic [2:0] low);
      logic [2:0] lvl;
      top_level = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         lvl = low + 3'(i) + 3'd1;
         if (vec[lvl]) top_level = {1'b1, lvl};
      end
   endfunction

   function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] low);
      return lvl - low - 3'd1;
   endfunction

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < SYNC_STAGES; i++) ir_sync_q[i] <= '0;
         inta_sync_q <= '1;
      end else begin
         ir_sync_q[0] <= IR;
         for (int i = 1; i < SYNC_STAGES; i++) ir_sync_q[i] <= ir_sync_q[i-1];
         inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], INTA};
      end
   end

   assign ir_s   = ir_sync_q[SYNC_STAGES-1];
   assign inta_s = inta_sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      ack_lvl_d  = ack_lvl_q;
      spurious_d = spurious_q;
      lo_pri_d   = lo_pri_q;
      rot_aeoi_d = rot_aeoi_q;
      isr_d      = isr_q;
      data_en_d  = data_en_q;
      data_out_d = data_out_q;
      ack_mask   = '0;

      inta_fall = inta_prev_q & ~inta_s;
      inta_rise = ~inta_prev_q & inta_s;
      {cand_vld, cand_lvl} = top_level(irr_q & ~imr, lo_pri_q);
      {isr_vld, isr_lvl}   = top_level(isr_q, lo_pri_q);
      int_cond = cand_vld && (!isr_vld || (rank(cand_lvl, lo_pri_q) < rank(isr_lvl, lo_pri_q)));
      irq_d    = (state_q == S_IDLE) && !inta_fall && int_cond;

      case (state_q)
         S_IDLE: if (inta_fall) begin
            state_d    = S_ACK1;
            ack_lvl_d  = cand_vld ? cand_lvl : 3'd7;
            spurious_d = !cand_vld;
            if (cand_vld) begin
               isr_d[cand_lvl]    = 1'b1;
               ack_mask[cand_lvl] = 1'b1;
            end
         end
         S_ACK1: if (inta_rise) state_d = S_WAIT2;
         S_WAIT2: if (inta_fall) begin
            state_d    = S_ACK2;
            data_en_d  = 1'b1;
            data_out_d = {vectorBase, ack_lvl_q};
         end
         S_ACK2: if (inta_rise) begin
            state_d    = S_IDLE;
            data_en_d  = 1'b0;
            data_out_d = 8'h00;
            if (aeoi && !spurious_q) begin
               isr_d[ack_lvl_q] = 1'b0;
               if (rot_aeoi_q) lo_pri_d = ack_lvl_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Edge mode holds a request only while the line stays high.
      if (ltim) irr_d = ir_s;
      else      irr_d = (irr_q | (ir_s & ~ir_prev_q)) & ir_s;
      irr_d = irr_d & ~ack_mask;

      // EOI sees the ISR after this cycle's acknowledge update.
      {eoi_vld, eoi_lvl} = top_level(isr_d, lo_pri_q);
      if (ocw2Strobe) begin
         case (ocw2[7:5])
            3'b001: if (eoi_vld) isr_d[eoi_lvl] = 1'b0;
            3'b011: isr_d[ocw2[2:0]] = 1'b0;
            3'b101: if (eoi_vld) begin
               isr_d[eoi_lvl] = 1'b0;
               lo_pri_d       = eoi_lvl;
            end
            3'b111: begin
               isr_d[ocw2[2:0]] = 1'b0;
               lo_pri_d         = ocw2[2:0];
            end
            3'b110: lo_pri_d = ocw2[2:0];
            3'b100: rot_aeoi_d = 1'b1;
            3'b000: rot_aeoi_d = 1'b0;
            default: ;
         endcase
      end

      if (initStrobe) begin
         irr_d      = '0;
         isr_d      = '0;
         lo_pri_d   = 3'd7;
         rot_aeoi_d = 1'b0;
         state_d    = S_IDLE;
         irq_d      = 1'b0;
         data_en_d  = 1'b0;
         data_out_d = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= S_IDLE;
         irr_q       <= '0;
         isr_q       <= '0;
         ir_prev_q   <= '0;
         inta_prev_q <= 1'b1;
         lo_pri_q    <= 3'd7;
         rot_aeoi_q  <= 1'b0;
         ack_lvl_q   <= 3'd0;
         spurious_q  <= 1'b0;
         irq_q       <= 1'b0;
         data_en_q   <= 1'b0;
         data_out_q  <= 8'h00;
      end else begin
         // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
         state_q     <= state_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         ir_prev_q   <= ir_s;
         inta_prev_q <= inta_s;
         lo_pri_q    <= lo_pri_d;
         rot_aeoi_q  <= rot_aeoi_d;
         ack_lvl_q   <= ack_lvl_d;
         spurious_q  <= spurious_d;
         irq_q       <= irq_d;
         data_en_q   <= data_en_d;
         data_out_q  <= data_out_d;
      end
   end

   assign INT     = irq_q;
   assign dataOut = data_out_q;
   assign dataEn  = data_en_q;
   assign irr     = irr_q;
   assign isr     = isr_q;

endmodule
